adder_tree_pipe: RTL



---
 rtl/adder_tree_pkg.sv | 26 ++
 rtl/adder_tree_level.sv | 43 ++++
 rtl/adder_tree_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: width math and parameter legality.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package adder_tree_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Full-precision result width: one extra bit per tree level.
  function automatic int out_width(input int num_in, input int in_w);
    return in_w + clog2(num_in);
  endfunction

  // The tree pairs lanes at every level, so the lane count must halve cleanly to 1.
  function automatic bit num_in_valid(input int num_in);
    return (num_in >= 2) && ((num_in & (num_in - 1)) == 0);
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder-tree level: sums adjacent lane pairs into lanes one bit wider.
// Latency: 1 cycle from in_dat to out_dat.
// Backpressure: holds out_dat whenever en is low; en is the pipeline-wide advance.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int PAIRS  = 4,
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [2*PAIRS*W-1:0]     in_dat,
  output logic [PAIRS*(W+1)-1:0]   out_dat
);

  logic [PAIRS*(W+1)-1:0] sum_nxt;

  // Per-pair extend-then-add; the extra bit makes the add exact for both signednesses.
  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    logic [W-1:0] lane_a;
    logic [W-1:0] lane_b;
    logic [W:0]   ext_a;
    logic [W:0]   ext_b;

    assign lane_a = in_dat[(2*p)*W +: W];
    assign lane_b = in_dat[(2*p+1)*W +: W];
    assign ext_a  = (SIGNED != 0) ? {lane_a[W-1], lane_a} : {1'b0, lane_a};
    assign ext_b  = (SIGNED != 0) ? {lane_b[W-1], lane_b} : {1'b0, lane_b};
    assign sum_nxt[p*(W+1) +: W+1] = ext_a + ext_b;
  end

  // Register the pair sums; hold while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_dat <= '0;
    end else if (en) begin
      out_dat <= sum_nxt;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined NUM_IN-lane adder tree with tag sideband and valid/ready handshake.
// Latency: LEVELS+1 cycles from accept to valid_output when unstalled; 1 sum/cycle.
// Backpressure: a held result (valid_output & ~ready_output) freezes every stage and drops ready_input.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int IN_W   = 8,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  valid_input,
  output logic                                  ready_input,
  input  logic [NUM_IN*IN_W-1:0]                data_input,
  input  logic [TAG_W-1:0]                      tag_input,
  output logic                                  valid_output,
  input  logic                                  ready_output,
  output logic [out_width(NUM_IN, IN_W)-1:0]    result,
  output logic [TAG_W-1:0]                      tag_output
);

  localparam int LEVELS = clog2(NUM_IN);
  localparam int OUT_W  = out_width(NUM_IN, IN_W);

  // Reject lane counts the pairwise tree cannot reduce to a single sum.
  if (!num_in_valid(NUM_IN)) begin : g_bad_num_in
    $fatal(1, "adder_tree_pipe: NUM_IN must be a power of two and at least 2");
  end

  logic                         stall;
  logic                         en;
  logic [NUM_IN*IN_W-1:0]       s0_dat;
  logic [LEVELS:0]              vld_q;
  logic [LEVELS:0][TAG_W-1:0]   tag_q;

  // The whole pipe moves as one: only a result the consumer refuses can block it,
  // so bubbles never stall and are never squeezed out.
  assign stall       = valid_output & ~ready_output;
  assign en          = ~stall;
  assign ready_input = ~stall;

  // Stage 0: capture the raw lanes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_dat <= '0;
    end else if (en) begin
      s0_dat <= data_input;
    end
  end

  // Valid and tag shift chain, kept in lockstep with the data stages (index 0 = stage 0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[LEVELS-1:0], valid_input & ready_input};
      tag_q <= {tag_q[LEVELS-1:0], tag_input};
    end
  end

  // Reduction levels: level l turns NUM_IN>>l lanes of IN_W+l bits into half as many, one bit wider.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int PAIRS = NUM_IN >> (l + 1);
    localparam int W     = IN_W + l;

    logic [PAIRS*(W+1)-1:0] lvl_dat;

    if (l == 0) begin : g_first
      adder_tree_level #(
        .PAIRS  (PAIRS),
        .W      (W),
        .SIGNED (SIGNED)
      ) u_level (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_dat  (s0_dat),
        .out_dat (lvl_dat)
      );
    end else begin : g_next
      adder_tree_level #(
        .PAIRS  (PAIRS),
        .W      (W),
        .SIGNED (SIGNED)
      ) u_level (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_dat  (g_lvl[l-1].lvl_dat),
        .out_dat (lvl_dat)
      );
    end
  end

  // Outputs come straight from the last stage registers.
  assign result       = g_lvl[LEVELS-1].lvl_dat[OUT_W-1:0];
  assign valid_output = vld_q[LEVELS];
  assign tag_output   = tag_q[LEVELS];

endmodule
